// File: rtl/obb_pkg.sv
// obb_pkg
// Shared definitions for the oriented-bounding-box collision path.
// Contents:
//   COORD_W / AXIS_W / PROJ_W : default widths (Q10.6 coordinates, Q2.8 axes,
//                               Q13.14 projections with one guard bit)
//   obb_state_e               : collider FSM states
//   SEP_*                     : encoding of the separating axis output
//   obb_juice_t               : one juiced box (two unit axes + four vertices)
package obb_pkg;

  localparam int COORD_W = 16;
  localparam int AXIS_W  = 10;
  localparam int PROJ_W  = 27;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PROJ = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } obb_state_e;

  // The collider also uses these as indices into its latched axis table,
  // so the candidate axis index and the reported axis share one encoding.
  localparam logic [1:0] SEP_A_U = 2'd0;
  localparam logic [1:0] SEP_A_V = 2'd1;
  localparam logic [1:0] SEP_B_U = 2'd2;
  localparam logic [1:0] SEP_B_V = 2'd3;

  typedef struct packed {
    logic signed [AXIS_W-1:0]         u_x;
    logic signed [AXIS_W-1:0]         u_y;
    logic signed [AXIS_W-1:0]         v_x;
    logic signed [AXIS_W-1:0]         v_y;
    logic signed [3:0][COORD_W-1:0]   pt_x;
    logic signed [3:0][COORD_W-1:0]   pt_y;
  } obb_juice_t;

endpackage

// File: rtl/obb_project.sv
// obb_project
// Combinational projection of one vertex onto one axis: px*ax + py*ay.
// Ports:
//   px_i, py_i : vertex coordinates, signed Q10.6
//   ax_i, ay_i : axis components, signed Q2.8
//   proj_o     : full-precision signed projection (Q13.14 at default widths)
module obb_project #(
  parameter int COORD_W = obb_pkg::COORD_W,
  parameter int AXIS_W  = obb_pkg::AXIS_W,
  parameter int PROJ_W  = obb_pkg::PROJ_W
) (
  input  logic signed [COORD_W-1:0] px_i,
  input  logic signed [COORD_W-1:0] py_i,
  input  logic signed [AXIS_W-1:0]  ax_i,
  input  logic signed [AXIS_W-1:0]  ay_i,
  output logic signed [PROJ_W-1:0]  proj_o
);

  localparam int PRODW = COORD_W + AXIS_W;

  logic signed [PRODW-1:0] prodX;
  logic signed [PRODW-1:0] prodY;

  // Operands are sign-extended to the full product width first so nothing
  // is lost; the sum then gets one guard bit on top of the products.
  assign prodX  = PRODW'(px_i) * PRODW'(ax_i);
  assign prodY  = PRODW'(py_i) * PRODW'(ay_i);
  assign proj_o = PROJ_W'(prodX) + PROJ_W'(prodY);

endmodule

// File: rtl/obb_collider.sv
// obb_collider
// Multi-cycle separating-axis test between two oriented bounding boxes.
// Both boxes are captured when start is accepted; the four candidate axes
// (A.u, A.v, B.u, B.v) are then tried in order, stopping at the first one
// that separates the boxes.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   start               : request a test (only looked at while idle)
//   a_*/b_* axes        : unit axes of box A / box B, signed Q2.8
//   a_pt_*/b_pt_*       : four vertices of box A / box B, signed Q10.6
//   busy                : a test is in flight (LOAD through DONE)
//   done                : one-cycle pulse, result valid
//   collide, sep_axis   : result, held until the next accepted start
module obb_collider #(
  parameter int COORD_W = 16,
  parameter int AXIS_W  = 10
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic signed [AXIS_W-1:0]  a_u_x,
  input  logic signed [AXIS_W-1:0]  a_u_y,
  input  logic signed [AXIS_W-1:0]  a_v_x,
  input  logic signed [AXIS_W-1:0]  a_v_y,
  input  logic signed [AXIS_W-1:0]  b_u_x,
  input  logic signed [AXIS_W-1:0]  b_u_y,
  input  logic signed [AXIS_W-1:0]  b_v_x,
  input  logic signed [AXIS_W-1:0]  b_v_y,
  input  logic signed [COORD_W-1:0] a_pt_x [4],
  input  logic signed [COORD_W-1:0] a_pt_y [4],
  input  logic signed [COORD_W-1:0] b_pt_x [4],
  input  logic signed [COORD_W-1:0] b_pt_y [4],
  output logic                      busy,
  output logic                      done,
  output logic                      collide,
  output logic [1:0]                sep_axis
);

  import obb_pkg::*;

  localparam int PROJ_W_L = COORD_W + AXIS_W + 1;

  obb_state_e state_q, state_d;

  logic signed [AXIS_W-1:0]   axX_q  [4];
  logic signed [AXIS_W-1:0]   axY_q  [4];
  logic signed [COORD_W-1:0]  aPtX_q [4];
  logic signed [COORD_W-1:0]  aPtY_q [4];
  logic signed [COORD_W-1:0]  bPtX_q [4];
  logic signed [COORD_W-1:0]  bPtY_q [4];
  logic [1:0]                 axisIdx_q;
  logic [1:0]                 ptIdx_q;
  logic signed [PROJ_W_L-1:0] minA_q, maxA_q, minB_q, maxB_q;
  logic                       collide_q;
  logic [1:0]                 sep_q;

  logic signed [PROJ_W_L-1:0] projA, projB;
  logic                       separated;

  // Both boxes are projected onto the same current axis, one vertex each
  // per cycle.
  obb_project #(.COORD_W(COORD_W), .AXIS_W(AXIS_W), .PROJ_W(PROJ_W_L)) uProjA (
    .px_i   (aPtX_q[ptIdx_q]),
    .py_i   (aPtY_q[ptIdx_q]),
    .ax_i   (axX_q[axisIdx_q]),
    .ay_i   (axY_q[axisIdx_q]),
    .proj_o (projA)
  );

  obb_project #(.COORD_W(COORD_W), .AXIS_W(AXIS_W), .PROJ_W(PROJ_W_L)) uProjB (
    .px_i   (bPtX_q[ptIdx_q]),
    .py_i   (bPtY_q[ptIdx_q]),
    .ax_i   (axX_q[axisIdx_q]),
    .ay_i   (axY_q[axisIdx_q]),
    .proj_o (projB)
  );

  // Strict comparison: intervals that merely touch still count as overlap.
  assign separated = (maxA_q < minB_q) || (maxB_q < minA_q);

  // Next-state logic; an early exit to DONE happens on the first separating axis.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_PROJ;
      ST_PROJ: if (ptIdx_q == 2'd3) state_d = ST_CMP;
      ST_CMP:  state_d = (separated || axisIdx_q == 2'd3) ? ST_DONE : ST_PROJ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath. The boxes are captured on the edge that accepts start, so
  // upstream is free to move on as soon as LOAD is entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        axX_q[i]  <= '0;
        axY_q[i]  <= '0;
        aPtX_q[i] <= '0;
        aPtY_q[i] <= '0;
        bPtX_q[i] <= '0;
        bPtY_q[i] <= '0;
      end
      axisIdx_q <= '0;
      ptIdx_q   <= '0;
      minA_q    <= '0;
      maxA_q    <= '0;
      minB_q    <= '0;
      maxB_q    <= '0;
      collide_q <= 1'b0;
      sep_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            axX_q[SEP_A_U] <= a_u_x;
            axY_q[SEP_A_U] <= a_u_y;
            axX_q[SEP_A_V] <= a_v_x;
            axY_q[SEP_A_V] <= a_v_y;
            axX_q[SEP_B_U] <= b_u_x;
            axY_q[SEP_B_U] <= b_u_y;
            axX_q[SEP_B_V] <= b_v_x;
            axY_q[SEP_B_V] <= b_v_y;
            for (int i = 0; i < 4; i++) begin
              aPtX_q[i] <= a_pt_x[i];
              aPtY_q[i] <= a_pt_y[i];
              bPtX_q[i] <= b_pt_x[i];
              bPtY_q[i] <= b_pt_y[i];
            end
            axisIdx_q <= '0;
            ptIdx_q   <= '0;
            collide_q <= 1'b0;
            sep_q     <= '0;
          end
        end
        ST_PROJ: begin
          // The point index wraps back to 0 after vertex 3, ready for the next axis.
          ptIdx_q <= ptIdx_q + 2'd1;
          if (ptIdx_q == 2'd0) begin
            minA_q <= projA;
            maxA_q <= projA;
            minB_q <= projB;
            maxB_q <= projB;
          end else begin
            if (projA < minA_q) minA_q <= projA;
            if (projA > maxA_q) maxA_q <= projA;
            if (projB < minB_q) minB_q <= projB;
            if (projB > maxB_q) maxB_q <= projB;
          end
        end
        ST_CMP: begin
          if (separated) begin
            collide_q <= 1'b0;
            sep_q     <= axisIdx_q;
          end else if (axisIdx_q == 2'd3) begin
            collide_q <= 1'b1;
            sep_q     <= '0;
          end else begin
            axisIdx_q <= axisIdx_q + 2'd1;
            ptIdx_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign collide  = collide_q;
  assign sep_axis = sep_q;

endmodule
